// File: rtl/analytic_envelope.sv
// Envelope detector: floor(sqrt(Re^2 + Im^2)) of a complex sample.
// The root is found with a restoring bit-serial square root, one result bit per clock.
module analytic_envelope #(
  parameter int IN_WIDTH = 36
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       stopDataInFlag,
  input  logic signed [IN_WIDTH-1:0] dataInRe,
  input  logic signed [IN_WIDTH-1:0] dataInIm,
  input  logic                       dataInValid,
  output logic                       dataInReady,
  output logic        [IN_WIDTH-1:0] dataOut,
  output logic                       dataOutValid
);

  localparam int SW = 2 * IN_WIDTH;
  localparam int RW = IN_WIDTH + 3;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(IN_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, READY, SQUARE, ROOT, STOP} state_t;

  state_t                     state;
  logic signed [IN_WIDTH-1:0] re_q;
  logic signed [IN_WIDTH-1:0] im_q;
  logic        [SW-1:0]       sum_sq;
  logic        [IN_WIDTH-1:0] root;
  logic        [RW-1:0]       rem;
  logic        [CW-1:0]       count;
  logic                       stop_pending;

  logic signed [SW-1:0]       re_ext;
  logic signed [SW-1:0]       im_ext;
  logic signed [SW-1:0]       re_sq;
  logic signed [SW-1:0]       im_sq;
  logic        [SW-1:0]       sum_next;
  logic        [RW-1:0]       rem_shift;
  logic        [RW-1:0]       trial;
  logic        [RW-1:0]       rem_next;
  logic        [IN_WIDTH-1:0] root_next;

  // Sum of squares and one restoring square-root step.
  always_comb begin
    re_ext    = re_q;
    im_ext    = im_q;
    re_sq     = re_ext * re_ext;
    im_sq     = im_ext * im_ext;
    // Both squares are non-negative and their sum is at most 2^(SW-1).
    sum_next  = $unsigned(re_sq) + $unsigned(im_sq);
    rem_shift = (rem << 2) | RW'(sum_sq[SW-1 -: 2]);
    trial     = {1'b0, root, 2'b01};
    if (rem_shift >= trial) begin
      rem_next  = rem_shift - trial;
      root_next = {root[IN_WIDTH-2:0], 1'b1};
    end else begin
      rem_next  = rem_shift;
      root_next = {root[IN_WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      re_q         <= '0;
      im_q         <= '0;
      sum_sq       <= '0;
      root         <= '0;
      rem          <= '0;
      count        <= '0;
      stop_pending <= 1'b0;
      dataOut      <= '0;
      dataOutValid <= 1'b0;
      dataInReady  <= 1'b0;
    end else begin
      dataOutValid <= 1'b0;
      case (state)
        IDLE: begin
          dataOut <= '0;
          if (enable) begin
            state       <= READY;
            dataInReady <= 1'b1;
          end else begin
            dataInReady <= 1'b0;
          end
        end
        READY: begin
          if (stopDataInFlag) begin
            state       <= STOP;
            dataInReady <= 1'b0;
            dataOut     <= '0;
          end else if (!enable) begin
            state       <= IDLE;
            dataInReady <= 1'b0;
            dataOut     <= '0;
          end else if (dataInValid) begin
            re_q        <= dataInRe;
            im_q        <= dataInIm;
            state       <= SQUARE;
            dataInReady <= 1'b0;
          end else begin
            dataInReady <= 1'b1;
          end
        end
        SQUARE: begin
          sum_sq <= sum_next;
          root   <= '0;
          rem    <= '0;
          count  <= '0;
          state  <= ROOT;
          if (stopDataInFlag) begin
            stop_pending <= 1'b1;
          end
        end
        ROOT: begin
          root   <= root_next;
          rem    <= rem_next;
          sum_sq <= {sum_sq[SW-3:0], 2'b00};
          count  <= count + CW'(1);
          if (count == LAST_ITER) begin
            dataOut      <= root_next;
            dataOutValid <= 1'b1;
            // A stop raised on the final iteration is honoured like an earlier one.
            if (stop_pending || stopDataInFlag) begin
              state        <= STOP;
              stop_pending <= 1'b1;
              dataInReady  <= 1'b0;
            end else begin
              state        <= READY;
              dataInReady  <= 1'b1;
            end
          end else if (stopDataInFlag) begin
            stop_pending <= 1'b1;
          end
        end
        STOP: begin
          dataOut     <= '0;
          dataInReady <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          dataOut     <= '0;
          dataInReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/analytic_envelope.md
# analytic_envelope

Computes the envelope |x| = floor(sqrt(Re² + Im²)) of the analytic signal produced by the Hilbert-transform stage. It sits directly downstream of that stage and consumes its real and imaginary output pair. It returns one unsigned magnitude per accepted sample through an iterative bit-serial square root. A valid/ready handshake governs input acceptance, and it uses the same IDLE / run / STOP control style as the rest of the processing chain.

## Interface
- IN_WIDTH, 36, width of each signed input component; also the width of the unsigned output.
- clock  input  1  system clock. All logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  starts operation from IDLE. Deasserting it in READY returns the block to IDLE.
- stopDataInFlag  input  1  end-of-data request. The block stops after any in-flight sample completes.
- dataInRe  input  IN_WIDTH  signed real component.
- dataInIm  input  IN_WIDTH  signed imaginary component.
- dataInValid  input  1  the input pair is valid this cycle.
- dataInReady  output  1  the block accepts a sample this cycle. It is high only in READY.
- dataOut  output  IN_WIDTH  unsigned envelope, floor(sqrt(Re²+Im²)).
- dataOutValid  output  1  one-cycle pulse marking a new dataOut.

## Operation
- **States:** IDLE, READY, SQUARE, ROOT, STOP.
- **Reset:** state=IDLE, dataOut=0, dataOutValid=0, dataInReady=0, stopPending=0. Internal accumulators are cleared.
- **IDLE:**
  - enable=1 → READY.
  - Outputs are held at 0.
- **READY:**
  - stopDataInFlag=1 → STOP. Stop has priority over a simultaneous dataInValid, so that sample is not accepted.
  - Else enable=0 → IDLE.
  - Else dataInValid=1 → latch Re and Im, then → SQUARE.
- **SQUARE:**
  - Register sumSq = Re·Re + Im·Im as an unsigned 2·IN_WIDTH-bit value; it cannot overflow.
  - Clear the root, remainder and counter, then → ROOT.
- **ROOT:**
  - Restoring digit-by-digit square root, one result bit per cycle, MSB first, exactly IN_WIDTH iterations.
  - Each iteration: rem = (rem<<2) | next two bits of sumSq; trial = (root<<2)|1.
  - If rem ≥ trial: rem −= trial and root = (root<<1)|1. Otherwise root = root<<1.
  - On the last iteration: dataOut ← final root, dataOutValid ← 1 for that one cycle. Then → STOP if stopPending, else → READY.
- **stopDataInFlag in SQUARE or ROOT:** sets stopPending, which is sticky. The current sample still completes and is output.
- **STOP:**
  - dataOut=0, dataOutValid=0, dataInReady=0.
  - STOP is terminal until reset; enable is ignored.
- **Held values:** dataOut holds its last result between pulses in READY, SQUARE and ROOT. It is forced to 0 only in IDLE and STOP.
- **Extreme input:** Re=Im=−2^(IN_WIDTH−1) gives sumSq=2^(2·IN_WIDTH−1). The result fits in IN_WIDTH bits with no saturation needed.
- **Reset mid-computation:** reset in any state aborts the computation and returns to the reset values on the next edge. No dataOutValid is produced for the aborted sample.

## Timing
- **Acceptance:** a sample is accepted at edge T when dataInReady && dataInValid.
- **Latency:** SQUARE occupies cycle T+1 and ROOT occupies cycles T+2 … T+IN_WIDTH+1. dataOutValid is high during cycle T+IN_WIDTH+2, which is 38 cycles for IN_WIDTH=36.
- **Ready overlap:** dataInReady rises in the same cycle as the dataOutValid pulse, as the state returns to READY.
- **Throughput:** the minimum spacing between accepted samples is IN_WIDTH+2 cycles.
- **Backpressure:** the upstream stage must hold dataInRe, dataInIm and dataInValid until accepted. Inputs arriving while dataInReady=0 are ignored, not queued.
- **Combinational paths:** dataInReady is a registered decode of state. There is no combinational path from any input to any output.

## Test plan
- **Basic:** reset, then enable=1. Send (Re,Im)=(3,4), then (−3,4), then (0,0), then (1,1) → dataOut=5, 5, 0, 1. Each result arrives with a single-cycle dataOutValid exactly 38 cycles after its acceptance edge.
- **Extremes:**
  - (−2^35, 0) → dataOut=34359738368.
  - (−2^35, −2^35) → dataOut equals the floor of the model's exact integer sqrt.
  - (2^35−1, 2^35−1) → matches the model.
  - No X and no overflow in any case.
- **Handshake:**
  - Hold dataInValid=1 continuously with a changing value each cycle. Only the values present on cycles where dataInReady=1 are processed, at spacing 38.
  - Dropping dataInValid in READY keeps the block in READY with dataOut unchanged.
- **Stop mid-sample:** pulse stopDataInFlag during ROOT → the in-flight result is still output. The block then enters STOP, with dataInReady=0 and dataOut=0 the following cycle, and further samples are ignored.
- **Stop vs. valid:** assert stopDataInFlag and dataInValid together in READY → no acceptance, no dataOutValid, and the block enters STOP.
- **Reset mid-computation:** assert reset 10 cycles into ROOT for (3,4) → no output pulse and all outputs return to 0. After re-enabling, (6,8) → dataOut=10 with normal latency.
